alu_exec_unit: RTL

- Execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU control decoder.
- Performs logic, add/sub and set-less-than in one cycle, plus an iterative unsigned multiply over WIDTH cycles.
- Uses a valid/ready handshake on both sides, so the multi-cycle CPU controller can stall on long operations.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_multu_seq.sv | 73 +++++++
 rtl/alu_exec_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared constants for the execute-stage ALU: the 4-bit ALU
//                control codes (also emitted by the ALU control decoder) and
//                the execute-unit state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_MULTU = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_multu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_multu_seq
//  Description : Iterative unsigned shift-add multiplier. One multiplier bit
//                is consumed per cycle; done_o pulses for one cycle once all
//                WIDTH bits have been processed, with product_o valid then.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                start_i         - load operands and begin (one-cycle pulse)
//                a_i, b_i        - multiplicand / multiplier
//                done_o          - product ready (one-cycle pulse)
//                product_o       - 2*WIDTH-bit unsigned product
//  Revision    : 1.0  initial release
// ============================================================================
module alu_multu_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] r_mcand_q;
    logic [WIDTH-1:0]   r_mplier_q;
    logic [2*WIDTH-1:0] r_prod_q;
    logic [CW-1:0]      r_cnt_q;
    logic               r_busy_q;
    logic               r_done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand_q  <= '0;
            r_mplier_q <= '0;
            r_prod_q   <= '0;
            r_cnt_q    <= '0;
            r_busy_q   <= 1'b0;
            r_done_q   <= 1'b0;
        end else begin
            r_done_q <= 1'b0;
            if (start_i) begin
                r_mcand_q  <= {{WIDTH{1'b0}}, a_i};
                r_mplier_q <= b_i;
                r_prod_q   <= '0;
                r_cnt_q    <= '0;
                r_busy_q   <= 1'b1;
            end else if (r_busy_q) begin
                if (r_mplier_q[0]) begin
                    r_prod_q <= r_prod_q + r_mcand_q;
                end
                r_mcand_q  <= r_mcand_q << 1;
                r_mplier_q <= r_mplier_q >> 1;
                // The iteration with the counter at WIDTH-1 is the last one;
                // done is registered so the product already includes it.
                if (r_cnt_q == CW'(WIDTH - 1)) begin
                    r_busy_q <= 1'b0;
                    r_done_q <= 1'b1;
                end else begin
                    r_cnt_q <= r_cnt_q + 1'b1;
                end
            end
        end
    end

    assign done_o    = r_done_q;
    assign product_o = r_prod_q;

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_unit
//  Description : Execute-stage ALU with valid/ready handshakes. Logic,
//                add/sub and SLT complete in one cycle; MULTU runs on the
//                iterative multiplier for WIDTH cycles.
//  Ports       : clk, reset                 - clock, sync active-high reset
//                in_valid / in_ready        - request handshake
//                alu_ctrl                   - 4-bit ALU control code
//                operand_a / operand_b      - operands
//                out_valid / out_ready      - result handshake
//                result_lo / result_hi      - result (hi = 0 unless MULTU)
//                zero                       - result_lo == 0
//                illegal                    - undefined alu_ctrl code
//  Revision    : 1.0  initial release
// ============================================================================
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_ctrl,
    input  logic [WIDTH-1:0]  operand_a,
    input  logic [WIDTH-1:0]  operand_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result_lo,
    output logic [WIDTH-1:0]  result_hi,
    output logic              zero,
    output logic              illegal
);

    state_t             r_state_q, w_state_d;
    logic [WIDTH-1:0]   r_lo_q, w_lo_d;
    logic [WIDTH-1:0]   r_hi_q, w_hi_d;
    logic               r_zero_q, w_zero_d;
    logic               r_ill_q, w_ill_d;

    logic               w_accept;
    logic               w_mul_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH-1:0]   w_single_res;
    logic               w_single_ill;

    assign in_ready    = (r_state_q == IDLE);
    assign out_valid   = (r_state_q == DONE);
    assign w_accept    = in_valid & in_ready;
    assign w_mul_start = w_accept & (alu_ctrl == ALU_MULTU);

    // Single-cycle datapath; its value is only registered on the accept edge,
    // so operand changes after accept never reach the outputs.
    always_comb begin
        w_single_res = '0;
        w_single_ill = 1'b0;
        case (alu_ctrl)
            ALU_AND: w_single_res = operand_a & operand_b;
            ALU_OR:  w_single_res = operand_a | operand_b;
            ALU_ADD: w_single_res = operand_a + operand_b;
            ALU_SUB: w_single_res = operand_a - operand_b;
            ALU_SLT: w_single_res = {{(WIDTH-1){1'b0}},
                                     ($signed(operand_a) < $signed(operand_b))};
            ALU_NOR: w_single_res = ~(operand_a | operand_b);
            default: w_single_ill = 1'b1;
        endcase
    end

    alu_multu_seq #(
        .WIDTH     (WIDTH)
    ) u_multu (
        .clk       (clk),
        .reset     (reset),
        .start_i   (w_mul_start),
        .a_i       (operand_a),
        .b_i       (operand_b),
        .done_o    (w_mul_done),
        .product_o (w_product)
    );

    always_comb begin
        w_state_d = r_state_q;
        w_lo_d    = r_lo_q;
        w_hi_d    = r_hi_q;
        w_zero_d  = r_zero_q;
        w_ill_d   = r_ill_q;
        case (r_state_q)
            IDLE: begin
                if (w_accept) begin
                    if (alu_ctrl == ALU_MULTU) begin
                        w_state_d = MUL;
                    end else begin
                        w_lo_d    = w_single_res;
                        w_hi_d    = '0;
                        w_zero_d  = (w_single_res == '0);
                        w_ill_d   = w_single_ill;
                        w_state_d = DONE;
                    end
                end
            end
            MUL: begin
                if (w_mul_done) begin
                    w_lo_d    = w_product[WIDTH-1:0];
                    w_hi_d    = w_product[2*WIDTH-1:WIDTH];
                    w_zero_d  = (w_product[WIDTH-1:0] == '0);
                    w_ill_d   = 1'b0;
                    w_state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= IDLE;
            r_lo_q    <= '0;
            r_hi_q    <= '0;
            r_zero_q  <= 1'b0;
            r_ill_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_lo_q    <= w_lo_d;
            r_hi_q    <= w_hi_d;
            r_zero_q  <= w_zero_d;
            r_ill_q   <= w_ill_d;
        end
    end

    assign result_lo = r_lo_q;
    assign result_hi = r_hi_q;
    assign zero      = r_zero_q;
    assign illegal   = r_ill_q;

endmodule
`default_nettype wire
